sram_memory_pipe: RTL
=====================

Name: sram_memory_pipe

Overview:
Parametrised successor to the board SRAM simulation model. It is a behavioural, synthesizable-style asynchronous-SRAM stand-in with the following features:
- configurable data width, depth and per-byte lane enables;
- programmable read latency (pipelined reads);
- a linear-wrap burst address counter.

It sits on the FPGA bench behind the SRAM controller. It also lets the controller be verified against multi-cycle and burst-capable parts.

Parameters:
DATA_WIDTH, 16, data bus width in bits; multiple of 8; BYTES = DATA_WIDTH/8.
ADDR_WIDTH, 18, external address bus width.
DEPTH, 131072, words stored; power of two, ≤ 2^ADDR_WIDTH; effective index = address mod DEPTH.
READ_LATENCY, 1, clock edges from read issue to data driven; legal 1..4.
BURST_LEN, 4, burst wrap length in words; power of two; 1 disables burst counter.

Ports:
CLOCK  input  1  model clock; all state on rising edge.
RESET  input  1  asynchronous, active-high reset.
SRAM_CE_n  input  1  chip enable, active low.
SRAM_WE_n  input  1  write enable, active low; priority over read.
SRAM_OE_n  input  1  output enable, active low.
SRAM_BE_n  input  BYTES  byte-lane write enables, active low; bit i covers D[8i+7:8i].
SRAM_ADV_n  input  1  address valid: low loads SRAM_A, high uses burst counter.
SRAM_A  input  ADDR_WIDTH  word address.
SRAM_D  inout  DATA_WIDTH  bidirectional data.
DATA_VALID  output  1  high when SRAM_D is driven with valid read data (bench observability).

Behaviour:
- Reset (async, immediate):
  - clears read pipeline valid flags, burst counter (to 0) and pipeline data regs (to 0);
  - DATA_VALID=0, SRAM_D=Z;
  - memory contents are NOT cleared;
  - while RESET=1, no access is issued.
- Access cycle = rising edge with CE_n=0.
- Effective address EA:
  - ADV_n=0 or BURST_LEN=1: EA = SRAM_A mod DEPTH.
  - Otherwise EA = counter.
- Burst counter, on every access cycle:
  - ADV_n=0: counter <= next(SRAM_A mod DEPTH).
  - ADV_n=1: counter <= next(counter).
  - next(x): low log2(BURST_LEN) bits increment modulo BURST_LEN, upper bits unchanged. Example: BURST_LEN=4, 0x107 -> 0x104.
  - Counter holds on non-access cycles.
- Write (CE_n=0, WE_n=0):
  - for each lane i with BE_n[i]=0, mem[EA] byte i <= SRAM_D byte i;
  - lanes with BE_n[i]=1 are unchanged;
  - all BE_n high = no-op, but the counter still advances.
  - A bubble (valid=0) enters the read pipeline.
- Read issue (CE_n=0, WE_n=1, OE_n=0):
  - stage0 data <= mem[EA], valid <= 1;
  - data is captured at issue, so a later write to the same address does not alter an in-flight read.
- CE_n=0, WE_n=1, OE_n=1: counter advances, bubble enters the pipeline (dummy access).
- Pipeline:
  - READ_LATENCY stages, shift every edge, bubble on non-read cycles;
  - the output stage is stage READ_LATENCY-1;
  - read issued at edge t is driven after edge t+READ_LATENCY-1 and sampled by the controller at edge t+READ_LATENCY;
  - READ_LATENCY=1 matches the legacy single-cycle model;
  - back-to-back reads give one word per cycle.
- Drive rule:
  - SRAM_D = output stage data iff CE_n=0 & OE_n=0 & WE_n=1 & out_valid; otherwise Z.
  - DATA_VALID follows the identical condition.
  - Deasserting OE_n or CE_n mid-pipeline tri-states the bus but does not flush the pipeline; data still shifts and is lost if not driven.
- Write immediately after read, same address: the read returns old data; the write lands.
- Read one cycle after write, same address: returns new data.
- Address bits ≥ log2(DEPTH) are ignored (aliasing).
- Bus contention: WE_n=0 forces Z regardless of pipeline contents.

Test Plan:
1. Defaults:
   - stimulus: write 0xBEEF at A=0x00010 (BE_n=00); next cycle read A=0x00010, OE_n=0;
   - response: SRAM_D=0xBEEF and DATA_VALID=1 after 1 edge; Z at all other times.
2. Byte lanes:
   - stimulus: write 0x1234 with BE_n=10 over stored 0xBEEF, then read;
   - response: 0xBE34.
3. READ_LATENCY=3:
   - stimulus: reads of A=1,2,3 back-to-back (data 0x11,0x22,0x33);
   - response: DATA_VALID rises on the 3rd edge after first issue; D=0x11,0x22,0x33 on consecutive cycles; then Z.
4. Burst wrap, BURST_LEN=4:
   - stimulus: ADV_n=0 at A=0x0006, then 3 cycles ADV_n=1 reading memory preloaded mem[n]=n;
   - response: data sequence 6,7,4,5.
5. Read-then-write hazard, READ_LATENCY=2:
   - stimulus: read A=5 (holds 0xAAAA), next cycle write 0x5555 to A=5, then read A=5;
   - response: first read returns 0xAAAA; second read returns 0x5555; D is Z during the write cycle.
6. Reset mid-burst:
   - stimulus: assert RESET between clock edges with 2 reads in flight;
   - response: DATA_VALID=0 and D=Z immediately; after release, an ADV_n=1 read accesses address 0; memory contents preserved.

Source files
------------

// File: rtl/sram_memory_pipe_if.sv
// Control and address signals from the SRAM controller to the SRAM model.
// The bidirectional data bus stays a plain inout port on the model.
interface sram_memory_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 18
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic                  SRAM_CE_n;
  logic                  SRAM_WE_n;
  logic                  SRAM_OE_n;
  logic                  SRAM_ADV_n;
  logic [BYTES-1:0]      SRAM_BE_n;
  logic [ADDR_WIDTH-1:0] SRAM_A;

  modport master (
    output SRAM_CE_n, SRAM_WE_n, SRAM_OE_n, SRAM_ADV_n, SRAM_BE_n, SRAM_A
  );

  modport slave (
    input SRAM_CE_n, SRAM_WE_n, SRAM_OE_n, SRAM_ADV_n, SRAM_BE_n, SRAM_A
  );
endinterface

// File: rtl/sram_memory_pipe.sv
// Asynchronous-SRAM stand-in with byte lanes, pipelined reads of programmable
// latency and a linear-wrap burst address counter.
module sram_memory_pipe #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 18,
  parameter int DEPTH        = 131072,
  parameter int READ_LATENCY = 1,
  parameter int BURST_LEN    = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  sram_memory_pipe_if.slave     bus,
  inout  wire  [DATA_WIDTH-1:0] SRAM_D,
  output logic                  DATA_VALID
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0]      BURST_MASK = IDX_W'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_MASK = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_pipe_d [READ_LATENCY];
  logic [READ_LATENCY-1:0] r_pipe_v;

  logic             w_access;
  logic             w_write;
  logic             w_read;
  logic             w_drive;
  logic [IDX_W-1:0] w_a_idx;
  logic [IDX_W-1:0] w_ea;
  logic [IDX_W-1:0] w_cnt_src;
  logic [IDX_W-1:0] w_cnt_next;

  // Wrap only the low log2(BURST_LEN) bits; BURST_LEN=1 gives an empty mask.
  function automatic logic [IDX_W-1:0] burst_next(input logic [IDX_W-1:0] x);
    logic [IDX_W-1:0] inc;
    inc = x + 1'b1;
    return (x & ~BURST_MASK) | (inc & BURST_MASK);
  endfunction

  assign w_access   = !bus.SRAM_CE_n && !RESET;
  assign w_write    = w_access && !bus.SRAM_WE_n;
  assign w_read     = w_access && bus.SRAM_WE_n && !bus.SRAM_OE_n;
  assign w_a_idx    = IDX_W'(bus.SRAM_A & DEPTH_MASK);
  assign w_ea       = (!bus.SRAM_ADV_n || BURST_LEN == 1) ? w_a_idx : r_cnt;
  assign w_cnt_src  = !bus.SRAM_ADV_n ? w_a_idx : r_cnt;
  assign w_cnt_next = burst_next(w_cnt_src);

  always_ff @(posedge CLOCK) begin
    if (w_write) begin
      for (int i = 0; i < BYTES; i++) begin
        if (!bus.SRAM_BE_n[i]) begin
          r_mem[w_ea][8*i +: 8] <= SRAM_D[8*i +: 8];
        end
      end
    end
  end

  // Read data is captured at issue, so later writes cannot disturb it in flight.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_cnt    <= '0;
      r_pipe_v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pipe_d[i] <= '0;
      end
    end else begin
      if (w_access) begin
        r_cnt <= w_cnt_next;
      end
      r_pipe_v[0] <= w_read;
      if (w_read) begin
        r_pipe_d[0] <= r_mem[w_ea];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_v[i] <= r_pipe_v[i-1];
        r_pipe_d[i] <= r_pipe_d[i-1];
      end
    end
  end

  assign w_drive    = !bus.SRAM_CE_n && !bus.SRAM_OE_n && bus.SRAM_WE_n &&
                      r_pipe_v[READ_LATENCY-1];
  assign SRAM_D     = w_drive ? r_pipe_d[READ_LATENCY-1] : {DATA_WIDTH{1'bz}};
  assign DATA_VALID = w_drive;
endmodule
